// File: rtl/score_display_sched.sv
// Shares the two-digit 7-segment score display between the player and dealer hands.
// The two sources get round-robin dwell slots. Each score is converted to tens/ones by
// repeated subtraction, and a bust hand (>21) blinks.
module score_display_sched #(
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned BLINK_CYCLES = 12500000,
  parameter int unsigned SCORE_W      = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] p_score,
  input  logic               p_valid,
  input  logic [SCORE_W-1:0] d_score,
  input  logic               d_valid,
  input  logic               dealer_reveal,
  output logic [0:6]         seg_ones,
  output logic [0:6]         seg_tens,
  output logic               show_dealer,
  output logic               busy
);

  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [0:6]         SEG_BLANK  = 7'b1111111;
  localparam logic               SRC_PLAYER = 1'b0;
  localparam logic               SRC_DEALER = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_CONVERT = 2'd2,
    S_SHOW    = 2'd3
  } state_e;

  // Digit to active-low segment pattern a..g
  function automatic logic [0:6] seg_of(input logic [3:0] digit);
    logic [0:6] pat;
    case (digit)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0001100;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  state_e               state_q, state_d;
  logic                 sel_q, sel_d;
  logic [SCORE_W-1:0]   rem_q, rem_d;
  logic [SCORE_W-1:0]   snap_q, snap_d;
  logic [1:0]           tens_q, tens_d;
  logic                 keep_dwell_q, keep_dwell_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_phase_q, blink_phase_d;
  logic [0:6]           disp_tens_q, disp_tens_d;
  logic [0:6]           disp_ones_q, disp_ones_d;
  logic [0:6]           seg_tens_q, seg_tens_d;
  logic [0:6]           seg_ones_q, seg_ones_d;
  logic                 show_dealer_q, show_dealer_d;
  logic                 busy_q, busy_d;

  logic                 p_elig, d_elig, sel_elig, other_elig, dwell_done;
  logic [SCORE_W-1:0]   live_score;
  logic [0:6]           tens_pat;

  assign p_elig     = p_valid;
  assign d_elig     = d_valid & dealer_reveal;
  assign sel_elig   = (sel_q == SRC_DEALER) ? d_elig : p_elig;
  assign other_elig = (sel_q == SRC_DEALER) ? p_elig : d_elig;
  assign live_score = (sel_q == SRC_DEALER) ? d_score : p_score;
  assign dwell_done = (dwell_q == DWELL_LAST);
  assign tens_pat   = (tens_q == 2'd0) ? SEG_BLANK : seg_of({2'b00, tens_q});

  // Scheduler, converter, blink timer and display next-state logic
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rem_d         = rem_q;
    snap_d        = snap_q;
    tens_d        = tens_q;
    keep_dwell_d  = keep_dwell_q;
    dwell_d       = dwell_q;
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    disp_tens_d   = disp_tens_q;
    disp_ones_d   = disp_ones_q;
    seg_tens_d    = seg_tens_q;
    seg_ones_d    = seg_ones_q;
    show_dealer_d = show_dealer_q;

    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    case (state_q)
      S_IDLE: begin
        if (p_elig || d_elig) begin
          state_d      = S_LOAD;
          sel_d        = other_elig ? ~sel_q : sel_q;
          keep_dwell_d = 1'b0;
        end
      end
      S_LOAD: begin
        rem_d   = live_score;
        snap_d  = live_score;
        tens_d  = 2'd0;
        state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (rem_q >= SCORE_W'(10)) begin
          rem_d  = rem_q - SCORE_W'(10);
          tens_d = tens_q + 2'd1;
        end else begin
          state_d       = S_SHOW;
          disp_tens_d   = tens_pat;
          disp_ones_d   = seg_of(rem_q[3:0]);
          show_dealer_d = sel_q;
          if (!keep_dwell_q) begin
            dwell_d = '0;
          end
        end
      end
      S_SHOW: begin
        dwell_d = dwell_done ? '0 : dwell_q + DWELL_W'(1);
        if (!sel_elig) begin
          if (other_elig) begin
            state_d      = S_LOAD;
            sel_d        = ~sel_q;
            keep_dwell_d = 1'b0;
          end else begin
            state_d     = S_IDLE;
            disp_tens_d = SEG_BLANK;
            disp_ones_d = SEG_BLANK;
            seg_tens_d  = SEG_BLANK;
            seg_ones_d  = SEG_BLANK;
          end
        end else if (live_score != snap_q) begin
          state_d      = S_LOAD;
          keep_dwell_d = 1'b1;
        end else if (dwell_done && other_elig) begin
          state_d      = S_LOAD;
          sel_d        = ~sel_q;
          keep_dwell_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Display digits while showing; bust hands blank on the odd blink phase
    if (state_d == S_SHOW) begin
      if ((snap_d > SCORE_W'(21)) && blink_phase_d) begin
        seg_tens_d = SEG_BLANK;
        seg_ones_d = SEG_BLANK;
      end else begin
        seg_tens_d = disp_tens_d;
        seg_ones_d = disp_ones_d;
      end
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_CONVERT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sel_q         <= SRC_DEALER;
      rem_q         <= '0;
      snap_q        <= '0;
      tens_q        <= 2'd0;
      keep_dwell_q  <= 1'b0;
      dwell_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      disp_tens_q   <= SEG_BLANK;
      disp_ones_q   <= SEG_BLANK;
      seg_tens_q    <= SEG_BLANK;
      seg_ones_q    <= SEG_BLANK;
      show_dealer_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      rem_q         <= rem_d;
      snap_q        <= snap_d;
      tens_q        <= tens_d;
      keep_dwell_q  <= keep_dwell_d;
      dwell_q       <= dwell_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      disp_tens_q   <= disp_tens_d;
      disp_ones_q   <= disp_ones_d;
      seg_tens_q    <= seg_tens_d;
      seg_ones_q    <= seg_ones_d;
      show_dealer_q <= show_dealer_d;
      busy_q        <= busy_d;
    end
  end

  assign seg_tens    = seg_tens_q;
  assign seg_ones    = seg_ones_q;
  assign show_dealer = show_dealer_q;
  assign busy        = busy_q;

endmodule

// File: doc/score_display_sched.md
Name: score_display_sched

Overview:
- Shares the two-digit 7-segment score display between the player hand and the dealer hand in the BlackJack design.
- Time-multiplexes the two scores with round-robin dwell scheduling.
- Converts the selected 5-bit score to tens/ones sequentially by repeated subtraction.
- Drives active-low segment patterns and blinks the display when the shown hand is bust (>21).

Parameters:
- DWELL_CYCLES, 50000000, clock cycles each source stays displayed before rescheduling (1 s at 50 MHz).
- BLINK_CYCLES, 12500000, half-period of the bust blink, in clock cycles.
- SCORE_W, 5, width of the score inputs; fixed at 5 (range 0..31).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- p_score  input  SCORE_W  player hand total.
- p_valid  input  1  player score is meaningful.
- d_score  input  SCORE_W  dealer hand total.
- d_valid  input  1  dealer score is meaningful.
- dealer_reveal  input  1  dealer hand may be shown.
- seg_ones  output  [0:6]  ones digit, segments a..g, active-low.
- seg_tens  output  [0:6]  tens digit, segments a..g, active-low.
- show_dealer  output  1  1 = dealer score on display, 0 = player score.
- busy  output  1  high in LOAD or CONVERT.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state IDLE.
  - seg_ones and seg_tens = 1111111 (blank).
  - show_dealer = 0, busy = 0.
  - dwell counter, blink counter and blink_phase = 0.
  - last source = dealer, so the player is chosen first.
- Segment encoding, digit to [0:6]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100.
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100.
  - Tens digit 0 is shown as blank (1111111), not as "0".
- Eligibility:
  - Player is eligible when p_valid = 1.
  - Dealer is eligible when d_valid = 1 and dealer_reveal = 1.
- FSM states: IDLE, LOAD, CONVERT, SHOW.
- IDLE:
  - Outputs are blank.
  - If any source is eligible, go to LOAD on the next edge.
  - Selection picks the source opposite the last one shown if it is eligible; otherwise it picks the only eligible source.
- LOAD (1 cycle):
  - Snapshot the selected score into rem and snap.
  - Clear tens_cnt; set sel.
- CONVERT:
  - Each cycle where rem >= 10: rem -= 10 and tens_cnt += 1.
  - When rem < 10: go to SHOW. On that same edge, seg_tens/seg_ones/show_dealer register the new value and the dwell counter clears.
  - Maximum 4 CONVERT cycles (score 31).
  - Display outputs hold their previous value throughout LOAD/CONVERT (no flicker).
- Latency: when IDLE sees eligibility at edge n, LOAD occupies cycle n+1 and CONVERT starts at n+2. For score 17, outputs are valid after edge n+3.
- SHOW:
  - The dwell counter increments each cycle.
  - When dwell reaches DWELL_CYCLES-1: if the other source is eligible, go to LOAD with the other source; else restart dwell and stay.
  - If the selected source's live score differs from snap: go to LOAD with the same source. Dwell is not cleared on this reload.
  - If the selected source loses eligibility: go to LOAD with the other source if it is eligible. Otherwise blank the outputs and go to IDLE.
  - Priority: eligibility loss > score change > dwell expiry.
- Blink:
  - The blink counter runs free from reset and toggles blink_phase every BLINK_CYCLES.
  - In SHOW with snap > 21, both digits output 1111111 while blink_phase = 1, and the digits show while blink_phase = 0.
  - Scores <= 21 never blink.
- Scores 22..31 display numerically, with tens digit 2 or 3.
- Reset asserted mid-conversion or mid-dwell returns to the reset values immediately; nothing is completed.
- Inputs are synchronous to clk; no metastability handling inside the block.

Test Plan (DWELL_CYCLES=20, BLINK_CYCLES=4):
- Player only: p_valid=1, p_score=17 -> busy for 3 cycles, then seg_tens=1001111, seg_ones=0001111, show_dealer=0. Display stays unchanged across dwell expiries.
- Both eligible: p_score=12, d_score=9, dealer_reveal=1 -> alternates every 20 cycles of SHOW (plus reload cycles). Dealer view shows seg_tens=1111111, seg_ones=0001100, show_dealer=1. Player is shown first.
- Bust: p_score=25 -> digits 2/5 (0010010/0100100) alternate with all-blank every 4 cycles. Score 21 shows 0010010/1001111 steady.
- Live update: while showing player 14, change p_score to 20 -> busy asserts the next cycle, display becomes 0010010/0000001, and dwell continues without reset.
- Eligibility loss: showing dealer, drop dealer_reveal -> reloads player in <= 6 cycles. Then drop p_valid -> both digits 1111111, state IDLE, busy=0.
- Reset mid-CONVERT with score 31: assert rst_n=0 -> outputs are blank asynchronously. Release -> rescheduling starts from IDLE with player first.
